// File: rtl/ds_dac_pkg.sv
// Shared definitions for the delta-sigma stereo mixer: route bit positions,
// integrator guard width and small constant/saturation helpers.
package ds_dac_pkg;

    localparam int ROUTE_L = 0;
    localparam int ROUTE_R = 1;

    // Extra bits on each second-order integrator above the sample width.
    localparam int MOD_INT_GUARD = 2;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r++;
        end
        return r;
    endfunction

    function automatic logic [31:0] sat_u(input logic [31:0] v, input int w);
        logic [31:0] m;
        m = (32'd1 << w) - 32'd1;
        return (v > m) ? m : v;
    endfunction

endpackage

// File: rtl/ds_mod.sv
// One-bit delta-sigma modulator; first-order carry type, or second-order error
// feedback when DS_DAC_ORDER2_EN is defined. Runs every cycle, no handshake.
module ds_mod #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             res_i,
    input  logic [WIDTH-1:0] din,
    output logic             dout
);

`ifdef DS_DAC_ORDER2_EN
    import ds_dac_pkg::*;

    localparam int IW = WIDTH + MOD_INT_GUARD;
    localparam int WW = IW + 2;
    localparam logic signed [WW-1:0] IMAX = $signed({3'b000, {(IW-1){1'b1}}});
    localparam logic signed [WW-1:0] IMIN = $signed({3'b111, {(IW-1){1'b0}}});

    logic signed [IW-1:0] int1, int2, n1, n2;
    logic signed [WW-1:0] fbw, dinw, e1, e2;

    always_comb begin
        dinw = $signed({{(WW-WIDTH){1'b0}}, din});
        fbw  = dout ? $signed({{(WW-WIDTH){1'b0}}, {WIDTH{1'b1}}}) : '0;
        e1   = $signed({{2{int1[IW-1]}}, int1}) + dinw - fbw;
        n1   = (e1 > IMAX) ? IMAX[IW-1:0] : (e1 < IMIN) ? IMIN[IW-1:0] : e1[IW-1:0];
        e2   = $signed({{2{int2[IW-1]}}, int2}) + $signed({{2{n1[IW-1]}}, n1}) - fbw;
        n2   = (e2 > IMAX) ? IMAX[IW-1:0] : (e2 < IMIN) ? IMIN[IW-1:0] : e2[IW-1:0];
    end

    always_ff @(posedge clk_i) begin
        if (res_i) begin
            int1 <= '0;
            int2 <= '0;
            dout <= 1'b0;
        end else begin
            int1 <= n1;
            int2 <= n2;
            dout <= ~n2[IW-1];
        end
    end
`else
    logic [WIDTH:0] acc;

    // The carry out of the phase accumulator is the output bit.
    always_ff @(posedge clk_i) begin
        if (res_i) begin
            acc  <= '0;
            dout <= 1'b0;
        end else begin
            acc  <= {1'b0, acc[WIDTH-1:0]} + {1'b0, din};
            dout <= acc[WIDTH];
        end
    end
`endif

endmodule

// File: rtl/ds_dac_mix.sv
// NCH-source stereo mixer with routing, shift and saturation feeding two ds_mod
// modulators (DS_DAC_ORDER2_EN selects second order). Load-to-mix latency 3; a load is accepted every cycle.
module ds_dac_mix
    import ds_dac_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NCH   = 2,
    parameter int SHIFT = 0
) (
    input  logic                 clk_i,
    input  logic                 res_i,
    input  logic                 load_i,
    input  logic [NCH*WIDTH-1:0] dac_i,
    input  logic [2*NCH-1:0]     route_i,
    output logic                 busy_o,
    output logic [WIDTH-1:0]     mix_l_o,
    output logic [WIDTH-1:0]     mix_r_o,
    output logic                 dac_l_o,
    output logic                 dac_r_o
);

    localparam int SW = WIDTH + clog2(NCH) + 1;

    logic [NCH*WIDTH-1:0] smp;
    logic [2*NCH-1:0]     rte;
    logic                 v0, v1, v2;
    logic [SW-1:0]        add_l, add_r, sum_l, sum_r;
    logic [WIDTH-1:0]     sat_l, sat_r;

    always_comb begin
        add_l = '0;
        add_r = '0;
        for (int k = 0; k < NCH; k++) begin
            if (rte[2*k+ROUTE_L]) add_l = add_l + SW'(smp[k*WIDTH +: WIDTH]);
            if (rte[2*k+ROUTE_R]) add_r = add_r + SW'(smp[k*WIDTH +: WIDTH]);
        end
    end

    always_comb begin
        sat_l = WIDTH'(sat_u(32'(sum_l >> SHIFT), WIDTH));
        sat_r = WIDTH'(sat_u(32'(sum_r >> SHIFT), WIDTH));
    end

    always_ff @(posedge clk_i) begin
        if (res_i) begin
            smp     <= '0;
            rte     <= '0;
            v0      <= 1'b0;
            v1      <= 1'b0;
            v2      <= 1'b0;
            sum_l   <= '0;
            sum_r   <= '0;
            mix_l_o <= '0;
            mix_r_o <= '0;
        end else begin
            v0 <= load_i;
            v1 <= v0;
            v2 <= v1;
            if (load_i) begin
                smp <= dac_i;
                rte <= route_i;
            end
            if (v0) begin
                sum_l <= add_l;
                sum_r <= add_r;
            end
            // Mix outputs hold between loads; the modulators keep running on them.
            if (v1) begin
                mix_l_o <= sat_l;
                mix_r_o <= sat_r;
            end
        end
    end

    assign busy_o = v0 | v1 | v2;

    ds_mod #(.WIDTH(WIDTH)) u_mod_l (
        .clk_i (clk_i),
        .res_i (res_i),
        .din   (mix_l_o),
        .dout  (dac_l_o)
    );

    ds_mod #(.WIDTH(WIDTH)) u_mod_r (
        .clk_i (clk_i),
        .res_i (res_i),
        .din   (mix_r_o),
        .dout  (dac_r_o)
    );

endmodule
